// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit feeding the HI/LO register pair.
//   Executes MULT, MULTU, DIV and DIVU one bit per cycle. It holds busy
//   high while working and presents a 2*WIDTH result on hi_out/lo_out,
//   together with a one-cycle done/hilo_we strobe.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request a new operation (sampled only in IDLE)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    multiplicand / dividend (rs)
//   src_b    multiplier / divisor (rt)
//   cancel   pipeline flush, aborts any operation in flight
//   busy     stall request, high in MUL/DIV/FIN
//   done     one-cycle result-valid pulse
//   hilo_we  HI/LO write enable, identical to done
//   hi_out   product high half or remainder
//   lo_out   product low half or quotient
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  // For MUL: {partial product high, remaining multiplier bits}.
  // For DIV: {partial remainder, remaining dividend / built quotient}.
  logic [2*WIDTH-1:0] acc;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]   operand;
  logic [1:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  // Operand magnitudes; op[0]=1 selects the unsigned variants.
  always_comb begin
    in_sign_a = ~op[0] & src_a[WIDTH-1];
    in_sign_b = ~op[0] & src_b[WIDTH-1];
    abs_a     = in_sign_a ? -src_a : src_a;
    abs_b     = in_sign_b ? -src_b : src_b;
  end

  // Shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole pair right. The
  // carry out of the add re-enters at the top, so nothing is lost.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring division step: bring in the next dividend bit and try the
  // subtraction. The top bit of the extended difference is the borrow.
  // When it succeeds the difference is below the divisor and fits in WIDTH.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, operand};
    if (!div_diff[WIDTH+1])
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Sign correction applied to the unsigned magnitude result in FIN. A zero
  // divisor bypasses the datapath and returns all ones / original dividend.
  // The -2^(W-1) / -1 case needs no special handling: the magnitude
  // quotient 2^(W-1) already reads back as the wrapped negative value.
  always_comb begin
    prod_neg = -acc;
    fin_hi   = acc[2*WIDTH-1:WIDTH];
    fin_lo   = acc[WIDTH-1:0];
    if (!op_q[1]) begin
      if (sign_a ^ sign_b) begin
        fin_hi = prod_neg[2*WIDTH-1:WIDTH];
        fin_lo = prod_neg[WIDTH-1:0];
      end
    end else if (operand == '0) begin
      fin_hi = a_orig;
      fin_lo = '1;
    end else begin
      if (sign_a ^ sign_b)
        fin_lo = -acc[WIDTH-1:0];
      if (sign_a)
        fin_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  // Control and datapath registers. cancel only ever leaves the held
  // result untouched; FIN ignores it so a result already computed is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      op_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      a_orig  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            op_q    <= op;
            sign_a  <= in_sign_a;
            sign_b  <= in_sign_b;
            a_orig  <= src_a;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            operand <= op[1] ? abs_b : abs_a;
            state   <= op[1] ? S_DIV : S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            acc <= (state == S_MUL) ? mul_next : div_next;
            cnt <= cnt + 1'b1;
            if (last_iter)
              state <= S_FIN;
          end
        end
        S_FIN: begin
          hi_q  <= fin_hi;
          lo_q  <= fin_lo;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The visible result is the freshly corrected value during FIN and the
  // held copy at all other times.
  assign done    = (state == S_FIN);
  assign hilo_we = done;
  assign busy    = (state != S_IDLE);
  assign hi_out  = done ? fin_hi : hi_q;
  assign lo_out  = done ? fin_lo : lo_q;

endmodule
